// File: rtl/adc_frontend_if.sv
// ADC front-end bus: raw ADC input, result/flags out, ack in.
// master = processor side, slave = adc_frontend.
interface adc_frontend_if;
  logic [7:0] adc_in;
  logic       sample_ack;
  logic [7:0] sample_data;
  logic       sample_ready;
  logic       overrun;
  logic       tick;

  modport master (
    output adc_in,
    output sample_ack,
    input  sample_data,
    input  sample_ready,
    input  overrun,
    input  tick
  );

  modport slave (
    input  adc_in,
    input  sample_ack,
    output sample_data,
    output sample_ready,
    output overrun,
    output tick
  );
endinterface

// File: rtl/adc_frontend.sv
// ADC front end: 2-flop sync, sample every DIV clocks, average
// 2^AVG_LOG2 samples, publish with sticky ready/overrun flags.
// Ports: clock, ctrl_reset_n (sync, active-low), bus (slave):
//   adc_in, sample_ack in; sample_data, sample_ready, overrun, tick out.
// Option: ADC_FRONTEND_DEADBAND_EN suppresses small changes.
module adc_frontend #(
  parameter int DIV      = 500,
  parameter int AVG_LOG2 = 2,
  parameter int DEADBAND = 2
) (
  input logic           clock,
  input logic           ctrl_reset_n,
  adc_frontend_if.slave bus
);

  localparam int DW = $clog2(DIV);
  localparam int AW = 8 + AVG_LOG2;
  localparam int NW = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [NW-1:0] N_LAST = NW'((1 << AVG_LOG2) - 1);

  if (DIV < 3) begin : g_div_chk
    $error("adc_frontend: DIV must be at least 3");
  end
  if (DEADBAND < 0) begin : g_db_chk
    $error("adc_frontend: DEADBAND must be non-negative");
  end

  typedef enum logic {
    S_ACC,
    S_PUB
  } state_t;

  state_t        r_state;
  logic [7:0]    r_sync1;
  logic [7:0]    r_sync2;
  logic [DW-1:0] r_div_cnt;
  logic [AW-1:0] r_acc;
  logic [NW-1:0] r_n_cnt;
  logic [7:0]    r_data;
  logic          r_ready;
  logic          r_ovr;

  state_t        w_state_nxt;
  logic [AW-1:0] w_acc_nxt;
  logic [NW-1:0] w_n_nxt;
  logic [7:0]    w_data_nxt;
  logic          w_ready_nxt;
  logic          w_ovr_nxt;
  logic          w_tick;
  logic          w_last;
  logic [AW-1:0] w_shift;
  logic [7:0]    w_avg;
  logic          w_pub;

  assign w_tick  = (r_div_cnt == DIV_LAST);
  assign w_last  = (r_n_cnt == N_LAST);
  assign w_shift = r_acc >> AVG_LOG2;
  assign w_avg   = w_shift[7:0];

`ifdef ADC_FRONTEND_DEADBAND_EN
  logic       r_seen;
  logic       w_seen_nxt;
  logic [8:0] w_diff;
  logic [8:0] w_abs;

  assign w_diff = {1'b0, w_avg} - {1'b0, r_data};
  assign w_abs  = w_diff[8] ? (~w_diff + 9'd1) : w_diff;
  // first result after reset always goes out
  assign w_pub  = !r_seen || (w_abs >= 9'(DEADBAND));
`else
  assign w_pub  = 1'b1;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_n_nxt     = r_n_cnt;
    w_data_nxt  = r_data;
    w_ready_nxt = r_ready;
    w_ovr_nxt   = r_ovr;
`ifdef ADC_FRONTEND_DEADBAND_EN
    w_seen_nxt  = r_seen;
`endif
    if (bus.sample_ack) begin
      w_ready_nxt = 1'b0;
      w_ovr_nxt   = 1'b0;
    end
    unique case (r_state)
      S_ACC: begin
        if (w_tick) begin
          w_acc_nxt = r_acc + AW'(r_sync2);
          w_n_nxt   = w_last ? '0 : r_n_cnt + NW'(1);
          if (w_last) w_state_nxt = S_PUB;
        end
      end
      S_PUB: begin
        w_state_nxt = S_ACC;
        w_acc_nxt   = '0;
        w_n_nxt     = '0;
        // publish overrides a same-cycle ack
        if (w_pub) begin
          w_data_nxt  = w_avg;
          w_ready_nxt = 1'b1;
          if (!bus.sample_ack && r_ready) w_ovr_nxt = 1'b1;
`ifdef ADC_FRONTEND_DEADBAND_EN
          w_seen_nxt  = 1'b1;
`endif
        end
      end
      default: w_state_nxt = S_ACC;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!ctrl_reset_n) begin
      r_state   <= S_ACC;
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_div_cnt <= '0;
      r_acc     <= '0;
      r_n_cnt   <= '0;
      r_data    <= '0;
      r_ready   <= 1'b0;
      r_ovr     <= 1'b0;
`ifdef ADC_FRONTEND_DEADBAND_EN
      r_seen    <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_sync1   <= bus.adc_in;
      r_sync2   <= r_sync1;
      r_div_cnt <= w_tick ? '0 : r_div_cnt + DW'(1);
      r_acc     <= w_acc_nxt;
      r_n_cnt   <= w_n_nxt;
      r_data    <= w_data_nxt;
      r_ready   <= w_ready_nxt;
      r_ovr     <= w_ovr_nxt;
`ifdef ADC_FRONTEND_DEADBAND_EN
      r_seen    <= w_seen_nxt;
`endif
    end
  end

  assign bus.sample_data  = r_data;
  assign bus.sample_ready = r_ready;
  assign bus.overrun      = r_ovr;
  assign bus.tick         = w_tick;

endmodule

// File: tb/tb_adc_frontend.sv
// Self-checking bench for adc_frontend (DIV=4, AVG_LOG2=2).
// Random/directed windows against a sample-history reference model.
module tb_adc_frontend;

  localparam int DIV  = 4;
  localparam int NAVG = 4;
  localparam int DB   = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  adc_frontend_if bus();

  adc_frontend #(
    .DIV(DIV),
    .AVG_LOG2(2),
    .DEADBAND(DB)
  ) dut (
    .clock(clk),
    .ctrl_reset_n(rst_n),
    .bus(bus)
  );

  int n_chk = 0;
  int n_err = 0;

  // reference model state
  int         c;
  logic [7:0] hist [0:4095];
  int         sum, n, pavg, first_rdy;
  bit         pend, m_rdy, m_ovr, m_seen;
  logic [7:0] m_data;

  // one-shot constant expectations checked after the next edge
  bit         d_en;
  logic [7:0] d_data;
  bit         d_rdy, d_ovr;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    c = 0; sum = 0; n = 0; pavg = 0;
    pend = 0; m_rdy = 0; m_ovr = 0; m_seen = 0;
    m_data = 8'h00; first_rdy = -1;
  endtask

  function automatic bit pub_ok();
    bit ok;
    ok = 1'b1;
`ifdef ADC_FRONTEND_DEADBAND_EN
    begin
      int d;
      d = pavg - int'(m_data);
      if (d < 0) d = -d;
      ok = !m_seen || (d >= DB);
    end
`endif
    return ok;
  endfunction

  task automatic step(input logic [7:0] v, input bit ack);
    bit was_rdy;
    @(negedge clk);
    rst_n = 1'b1;
    bus.adc_in = v;
    bus.sample_ack = ack;
    @(posedge clk);
    #1;
    c++;
    hist[c] = v;
    was_rdy = m_rdy;
    if (ack) begin
      m_rdy = 0;
      m_ovr = 0;
    end
    if (pend) begin
      pend = 0;
      if (pub_ok()) begin
        m_data = 8'(pavg);
        m_rdy = 1;
        m_seen = 1;
        if (!ack && was_rdy) m_ovr = 1;
      end
    end
    // value sampled at a tick went in two clocks earlier (synchroniser)
    if (c % DIV == 0) begin
      sum += int'(hist[c-2]);
      n++;
      if (n == NAVG) begin
        pend = 1;
        pavg = sum / NAVG;
        sum = 0;
        n = 0;
      end
    end
    if (first_rdy < 0 && bus.sample_ready === 1'b1) first_rdy = c;
    chk("data", bus.sample_data, m_data);
    chk("ready", bus.sample_ready, m_rdy);
    chk("overrun", bus.overrun, m_ovr);
    chk("tick", bus.tick, (c % DIV) == DIV - 1);
    if (d_en) begin
      d_en = 0;
      chk("dir_data", bus.sample_data, d_data);
      chk("dir_ready", bus.sample_ready, d_rdy);
      chk("dir_overrun", bus.overrun, d_ovr);
    end
  endtask

  task automatic do_reset(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      rst_n = 1'b0;
      bus.adc_in = 8'hFF;
      bus.sample_ack = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_data", bus.sample_data, 8'h00);
      chk("rst_ready", bus.sample_ready, 1'b0);
      chk("rst_overrun", bus.overrun, 1'b0);
      chk("rst_tick", bus.tick, 1'b0);
    end
    m_reset();
  endtask

  // one window = 4 blocks of DIV clocks, one sample value per block;
  // ackpos selects the cycle of the first block that carries an ack
  task automatic run_window(input logic [7:0] v0, input logic [7:0] v1,
                            input logic [7:0] v2, input logic [7:0] v3,
                            input int ackpos);
    logic [7:0] v [4];
    v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < DIV; i++)
        step(v[b], b == 0 && i == ackpos);
  endtask

  task automatic set_dir(input logic [7:0] dd, input bit dr, input bit dov);
    d_en = 1; d_data = dd; d_rdy = dr; d_ovr = dov;
  endtask

  task automatic rand_window(input int ackpos, output logic [7:0] avg);
    logic [7:0] r0, r1, r2, r3;
    r0 = 8'($urandom); r1 = 8'($urandom);
    r2 = 8'($urandom); r3 = 8'($urandom);
    avg = 8'((int'(r0) + int'(r1) + int'(r2) + int'(r3)) / 4);
    run_window(r0, r1, r2, r3, ackpos);
  endtask

  initial begin
    logic [7:0] a;
    d_en = 0;
    bus.adc_in = 8'hFF;
    bus.sample_ack = 1'b0;
    m_reset();
    do_reset(3);

    run_window(8'h80, 8'h80, 8'h80, 8'h80, -1);
    set_dir(8'h80, 1, 0);
    run_window(8'd10, 8'd11, 8'd12, 8'd13, 1);
    chk("first_ready", first_rdy, 17);
    set_dir(8'd11, 1, 0);
    run_window(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1);
    set_dir(8'hFF, 1, 0);

    rand_window(-1, a);
    set_dir(a, 1, 1);
    rand_window(2, a);
    set_dir(a, 1, 0);
    rand_window(-1, a);
    set_dir(a, 1, 1);
    rand_window(-1, a);
    set_dir(a, 1, 0);
    rand_window(0, a);

    for (int w = 0; w < 4; w++)
      rand_window(int'($urandom_range(0, 4)), a);

    // partial window then reset: the two samples must be discarded
    for (int i = 0; i < 2 * DIV; i++) step(8'd200, 1'b0);
    do_reset(2);
    run_window(8'h33, 8'h33, 8'h33, 8'h33, -1);
    set_dir(8'h33, 1, 0);
    step(8'h33, 1'b0);
    chk("first_ready_after_rst", first_rdy, 17);

`ifdef ADC_FRONTEND_DEADBAND_EN
    do_reset(1);
    run_window(8'd100, 8'd100, 8'd100, 8'd100, -1);
    set_dir(8'd100, 1, 0);
    run_window(8'd101, 8'd101, 8'd101, 8'd101, 1);
    set_dir(8'd100, 0, 0);
    run_window(8'd103, 8'd103, 8'd103, 8'd103, -1);
    set_dir(8'd103, 1, 0);
    step(8'd103, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
